// File: rtl/spi_ram_pkg.sv
// Package: spi_ram_pkg
// Shared types for the SPI-attached RAM burst controller.
//   spi_ram_op_e    : two-bit opcode carried in the top bits of a command word
//   spi_ram_state_e : controller FSM states (post-reset clear, idle, read hold)
package spi_ram_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } spi_ram_op_e;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_HOLD
    } spi_ram_state_e;

endpackage

// File: rtl/spi_ram_mem_array.sv
// Module: spi_ram_mem_array
// Plain storage array: one write port and one synchronous, enabled read port.
// The array has no reset; clearing is done by the controller through the
// write port.
// Ports:
//   clk      in   clock, rising edge
//   we       in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   re       in   read enable; rd_data updates only when set
//   rd_addr  in   read address
//   rd_data  out  registered read data, held between reads
module spi_ram_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Read data is only refreshed on an enabled read so the value stays
    // stable while the controller holds it out on the tx side.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spi_ram_burst_ctrl.sv
// Module: spi_ram_burst_ctrl
// Command-driven RAM sitting between an SPI slave rx path and tx path.
// Command words carry an opcode in the top two bits and a payload below it.
// Supports write/read address set, data write, registered data read, optional
// address auto-increment for bursts and a sequential clear after reset.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   din       in   command word {opcode, payload}
//   rx_valid  in   din valid
//   rx_ready  out  command accepted when rx_valid && rx_ready
//   dout      out  read data
//   tx_valid  out  dout valid, held until tx_ready
//   tx_ready  in   downstream consumes dout
//   busy      out  clear sequence in progress
module spi_ram_burst_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int AUTO_INC     = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy
);

    spi_ram_state_e    state;
    spi_ram_state_e    state_next;
    spi_ram_op_e       op;
    logic [ADDR_W-1:0] addr_wr;
    logic [ADDR_W-1:0] addr_rd;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] payload_addr;
    logic [DATA_W-1:0] payload_data;
    logic              accept;
    logic              dout_loaded;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic [DATA_W-1:0] rd_data;

    assign op           = spi_ram_op_e'(din[DATA_W+1:DATA_W]);
    assign payload_addr = din[ADDR_W-1:0];
    assign payload_data = din[DATA_W-1:0];
    assign accept       = rx_valid && rx_ready;

    // The array has no reset, so dout is forced to zero until the first read
    // after reset lands; afterwards it shows the held read register.
    assign dout = dout_loaded ? rd_data : '0;

    spi_ram_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (mem_waddr),
        .wr_data (mem_wdata),
        .re      (mem_re),
        .rd_addr (addr_rd),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake outputs and the write-port mux. During CLEAR the
    // clear counter owns the write port; otherwise the command path does.
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        busy       = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_waddr  = addr_wr;
        mem_wdata  = payload_data;
        case (state)
            ST_CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = '0;
                if (&clr_cnt) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (op == OP_WR_DATA) begin
                        mem_we = 1'b1;
                    end
                    if (op == OP_RD_DATA) begin
                        mem_re     = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address registers, clear counter and the dout-loaded flag. Address
    // increments wrap naturally at the register width.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_wr     <= '0;
            addr_rd     <= '0;
            clr_cnt     <= '0;
            dout_loaded <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end
            if (accept) begin
                case (op)
                    OP_WR_ADDR: addr_wr <= payload_addr;
                    OP_WR_DATA: begin
                        if (AUTO_INC != 0) begin
                            addr_wr <= addr_wr + ADDR_W'(1);
                        end
                    end
                    OP_RD_ADDR: addr_rd <= payload_addr;
                    OP_RD_DATA: begin
                        dout_loaded <= 1'b1;
                        if (AUTO_INC != 0) begin
                            addr_rd <= addr_rd + ADDR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
